// File: rtl/datamem_pipe_if.sv
// datamem_pipe_if: request/response bus between the load/store unit and datamem_pipe
interface datamem_pipe_if #(parameter int DATA_W = 64);
  logic req_valid, req_ready, req_write, req_signed;
  logic [63:0] req_addr;
  logic [3:0] req_size;
  logic [DATA_W-1:0] req_wdata, resp_rdata;
  logic resp_valid, resp_err;
  modport master(output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
                 input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave(input req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
                output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/datamem_pipe.sv
// datamem_pipe: pipelined byte-addressed memory with zero-init, access checks and load extension
module datamem_pipe #(
  parameter int MEM_BYTES = 1024,
  parameter int DATA_W = 64,
  parameter int LATENCY = 1,
  parameter int ZERO_INIT = 1
) (
  input logic clk,
  input logic reset,
  datamem_pipe_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int NW = MEM_BYTES / NB;
  localparam int WW = AW - LB;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [WW-1:0] cnt, cnt_n;
  logic [7:0] mem [MEM_BYTES];
  logic accept, err, legal_size, init_wr, fill;
  logic [64:0] end_addr;
  logic [AW-1:0] base;
  logic [DATA_W-1:0] raw, ext;
  logic pv [LATENCY];
  logic pe [LATENCY];
  logic [DATA_W-1:0] pd [LATENCY];
  // INIT walks every word once (or leaves at once without zeroing), then RUN forever.
  always_comb begin
    state_n = (state == INIT && (ZERO_INIT == 0 || cnt == WW'(NW - 1))) ? RUN : state;
    cnt_n = (state == INIT) ? cnt + WW'(1) : cnt;
  end
  // Reset restarts initialisation from word 0.
  always_ff @(posedge clk) begin
    state <= reset ? INIT : state_n;
    cnt <= reset ? '0 : cnt_n;
  end
  assign bus.req_ready = state == RUN && !reset;
  assign accept = bus.req_valid && bus.req_ready;
  assign init_wr = ZERO_INIT != 0 && state == INIT && !reset;
  assign legal_size = bus.req_size inside {4'd1, 4'd2, 4'd4, 4'd8} && 32'(bus.req_size) <= NB;
  assign end_addr = {1'b0, bus.req_addr} + {61'd0, bus.req_size};
  assign err = !legal_size || (bus.req_addr & (64'(bus.req_size) - 64'd1)) != 64'd0 || end_addr > 65'(MEM_BYTES);
  assign base = bus.req_addr[AW-1:0];
  // Gather the addressed bytes little-endian and sign- or zero-extend narrow loads.
  always_comb begin
    raw = '0;
    for (int k = 0; k < NB; k++)
      raw[8*k +: 8] = (k < 32'(bus.req_size)) ? mem[base + AW'(k)] : 8'h00;
    fill = bus.req_signed && 32'(bus.req_size) < NB &&
           (bus.req_size == 4'd1 ? raw[7] : bus.req_size == 4'd2 ? raw[15] : raw[31]);
    ext = raw;
    for (int b = 0; b < DATA_W; b++)
      if (b >= 8 * 32'(bus.req_size)) ext[b] = fill;
  end
  // Zero one word per cycle during INIT; commit error-free stores on the accept edge.
  always_ff @(posedge clk) begin
    if (init_wr)
      for (int k = 0; k < NB; k++) mem[{cnt, LB'(k)}] <= 8'h00;
    else if (accept && bus.req_write && !err)
      for (int k = 0; k < NB; k++)
        if (k < 32'(bus.req_size)) mem[base + AW'(k)] <= bus.req_wdata[8*k +: 8];
  end
  // Shift {valid, err, rdata} through LATENCY stages; reset drops whatever is in flight.
  always_ff @(posedge clk) begin
    pv[0] <= accept && !reset;
    pe[0] <= err;
    pd[0] <= (err || bus.req_write) ? '0 : ext;
    for (int i = 1; i < LATENCY; i++) begin
      pv[i] <= pv[i-1] && !reset;
      pe[i] <= pe[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign bus.resp_valid = pv[LATENCY-1] && !reset;
  assign bus.resp_err = bus.resp_valid && pe[LATENCY-1];
  assign bus.resp_rdata = bus.resp_valid ? pd[LATENCY-1] : '0;
endmodule

// File: tb/tb_datamem_pipe.sv
// tb_datamem_pipe: scoreboard bench driving a LATENCY 1 and a LATENCY 3 instance in lockstep
module tb_datamem_pipe;
  logic clk = 0, reset = 1, rv = 0, rw = 0, rs = 0;
  logic [63:0] ra = 0, rwd = 0;
  logic [3:0] rsz = 0;
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0;
  logic [64:0] q1[$], q3[$], exp1, exp3;
  int t3[$];
  datamem_pipe_if #(.DATA_W(64)) b1();
  datamem_pipe_if #(.DATA_W(64)) b3();
  assign b1.req_valid = rv;
  assign b1.req_write = rw;
  assign b1.req_addr = ra;
  assign b1.req_size = rsz;
  assign b1.req_signed = rs;
  assign b1.req_wdata = rwd;
  assign b3.req_valid = rv;
  assign b3.req_write = rw;
  assign b3.req_addr = ra;
  assign b3.req_size = rsz;
  assign b3.req_signed = rs;
  assign b3.req_wdata = rwd;
  datamem_pipe #(.LATENCY(1)) u1(.clk(clk), .reset(reset), .bus(b1.slave));
  datamem_pipe #(.LATENCY(3)) u3(.clk(clk), .reset(reset), .bus(b3.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mon_en) begin
    checks++;
    if (b1.resp_valid === 1'b1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_resp: got err=%b rdata=%h, none expected", b1.resp_err, b1.resp_rdata);
      end else begin
        exp1 = q1.pop_front();
        if ({b1.resp_err, b1.resp_rdata} !== exp1) begin
          errors++;
          $display("FAIL u1_resp: got err=%b rdata=%h, expected err=%b rdata=%h", b1.resp_err, b1.resp_rdata, exp1[64], exp1[63:0]);
        end
      end
    end else if (b1.resp_valid !== 1'b0 || b1.resp_err !== 1'b0 || b1.resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL u1_idle_outputs: got valid=%b err=%b rdata=%h, expected all 0", b1.resp_valid, b1.resp_err, b1.resp_rdata);
    end
  end
  always @(negedge clk) if (mon_en) begin
    checks++;
    if (b3.resp_valid === 1'b1) begin
      t3.push_back(cyc);
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL u3_unexpected_resp: got err=%b rdata=%h, none expected", b3.resp_err, b3.resp_rdata);
      end else begin
        exp3 = q3.pop_front();
        if ({b3.resp_err, b3.resp_rdata} !== exp3) begin
          errors++;
          $display("FAIL u3_resp: got err=%b rdata=%h, expected err=%b rdata=%h", b3.resp_err, b3.resp_rdata, exp3[64], exp3[63:0]);
        end
      end
    end else if (b3.resp_valid !== 1'b0 || b3.resp_err !== 1'b0 || b3.resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL u3_idle_outputs: got valid=%b err=%b rdata=%h, expected all 0", b3.resp_valid, b3.resp_err, b3.resp_rdata);
    end
  end
  task automatic issue(input logic w, input logic [63:0] a, input logic [3:0] sz, input logic sg,
                       input logic [63:0] wd, input logic ee, input logic [63:0] ed, input bit to3 = 1'b1);
    rv = 1; rw = w; ra = a; rsz = sz; rs = sg; rwd = wd;
    q1.push_back({ee, ed});
    if (to3) q3.push_back({ee, ed});
    @(negedge clk);
  endtask
  task automatic drain();
    rv = 0;
    for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: outstanding u1=%0d u3=%0d, expected 0", q1.size(), q3.size());
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    mon_en = 1;
    checks += 2;
    if ({b1.req_ready, b1.resp_valid, b1.resp_err, b1.resp_rdata} !== 67'd0) begin
      errors++;
      $display("FAIL u1_reset_values: got ready=%b valid=%b err=%b rdata=%h, expected 0", b1.req_ready, b1.resp_valid, b1.resp_err, b1.resp_rdata);
    end
    if ({b3.req_ready, b3.resp_valid, b3.resp_err, b3.resp_rdata} !== 67'd0) begin
      errors++;
      $display("FAIL u3_reset_values: got ready=%b valid=%b err=%b rdata=%h, expected 0", b3.req_ready, b3.resp_valid, b3.resp_err, b3.resp_rdata);
    end
    rv = 1; rw = 0; ra = 0; rsz = 8;
    repeat (2) @(negedge clk);
    rv = 0;
  endtask
  task automatic test_init();
    bit early = 0;
    reset = 0;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      if (i < 128 && (b1.req_ready !== 1'b0 || b3.req_ready !== 1'b0)) early = 1;
    end
    checks += 2;
    if (early) begin
      errors++;
      $display("FAIL init_ready_low: ready rose before edge 128, expected low through edge 127");
    end
    if (b1.req_ready !== 1'b1 || b3.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready_high: got u1=%b u3=%b after edge 128, expected 1", b1.req_ready, b3.req_ready);
    end
  endtask
  task automatic test_zero_loads();
    issue(0, 0, 8, 0, 0, 0, 0);
    issue(0, 504, 8, 0, 0, 0, 0);
    issue(0, 1016, 8, 1, 0, 0, 0);
    drain();
  endtask
  task automatic test_store_load();
    issue(1, 16, 8, 0, 64'h1122334455667788, 0, 0);
    issue(0, 16, 1, 0, 0, 0, 64'h88);
    issue(1, 16, 8, 0, 64'h1122334455667788, 0, 0);
    issue(0, 17, 1, 0, 0, 0, 64'h77);
    issue(1, 16, 8, 0, 64'h1122334455667788, 0, 0);
    issue(0, 23, 1, 0, 0, 0, 64'h11);
    issue(0, 20, 4, 0, 0, 0, 64'h11223344);
    drain();
  endtask
  task automatic test_sign();
    issue(1, 40, 1, 0, 64'h80, 0, 0);
    issue(0, 40, 1, 1, 0, 0, 64'hFFFFFFFFFFFFFF80);
    issue(0, 40, 1, 0, 0, 0, 64'h80);
    issue(1, 42, 2, 0, 64'h8001, 0, 0);
    issue(0, 42, 2, 1, 0, 0, 64'hFFFFFFFFFFFF8001);
    issue(0, 40, 4, 1, 0, 0, 64'hFFFFFFFF80010080);
    issue(0, 40, 8, 1, 0, 0, 64'h0000000080010080);
    drain();
  endtask
  task automatic test_errors();
    issue(1, 6, 4, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    issue(0, 6, 4, 0, 0, 1, 0);
    issue(0, 0, 8, 0, 0, 0, 0);
    issue(1, 1024, 8, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    issue(0, 0, 8, 0, 0, 0, 0);
    issue(1, 0, 3, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    issue(0, 0, 8, 0, 0, 0, 0);
    issue(1, 64'hFFFFFFFFFFFFFFF8, 8, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    issue(0, 64'hFFFFFFFFFFFFFFF8, 8, 0, 0, 1, 0);
    issue(0, 1016, 8, 0, 0, 0, 0);
    drain();
  endtask
  task automatic test_latency();
    int c0;
    bit bad = 0;
    for (int i = 0; i < 10; i++) issue(1, 64'(512 + 8 * i), 8, 0, 64'h0101010101010101 * 64'(i + 1), 0, 0);
    drain();
    t3.delete();
    c0 = cyc;
    for (int i = 0; i < 10; i++) issue(0, 64'(512 + 8 * i), 8, 0, 0, 0, 64'h0101010101010101 * 64'(i + 1));
    drain();
    checks += 2;
    if (t3.size() != 10) begin
      errors++;
      $display("FAIL latency_count: got %0d responses, expected 10", t3.size());
    end
    foreach (t3[i]) if (t3[i] != c0 + 3 + i) bad = 1;
    if (bad || t3.size() == 0) begin
      errors++;
      $display("FAIL latency_timing: first response at cycle %0d, expected %0d with consecutive pulses", t3.size() ? t3[0] : -1, c0 + 3);
    end
  endtask
  task automatic test_reset_inflight();
    issue(1, 200, 8, 0, 64'hDEADBEEF0BADF00D, 0, 0);
    issue(0, 200, 8, 0, 0, 0, 64'hDEADBEEF0BADF00D);
    drain();
    issue(0, 200, 8, 0, 0, 0, 64'hDEADBEEF0BADF00D, 0);
    issue(0, 208, 8, 0, 0, 0, 0, 0);
    #1 reset = 1;
    rv = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL inflight_u1: got %0d outstanding responses, expected 0", q1.size());
    end
    test_init();
    issue(0, 200, 8, 0, 0, 0, 0);
    drain();
  endtask
  initial begin
    test_reset();
    test_init();
    test_zero_loads();
    test_store_load();
    test_sign();
    test_errors();
    test_latency();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
